// File: rtl/reg_16bit_file_dump.sv
// Halt-time register-file dumper: reads the file pairwise through the A/B read
// ports and streams every word (with its index) over a valid/ready output.
module reg_16bit_file_dump #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              busy,
  output logic              wr_hold,
  output logic              done,
  output logic [ADDR_W-1:0] AddrA,
  output logic [ADDR_W-1:0] AddrB,
  input  logic [DATA_W-1:0] BusA,
  input  logic [DATA_W-1:0] BusB,
  output logic [DATA_W-1:0] dout,
  output logic [ADDR_W-1:0] dout_addr,
  output logic              dout_valid,
  input  logic              dout_ready,
  output logic [DATA_W-1:0] checksum
);

  // Handshake: a word transfers on any cycle where dout_valid && dout_ready.
  // Once raised, dout_valid holds with dout/dout_addr stable until that
  // transfer; dout_ready while dout_valid is low is ignored.

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    SEND_A = 3'd2,
    SEND_B = 3'd3,
    DONE   = 3'd4
  } state_t;

  localparam int K_W = ADDR_W - 1;
  localparam logic [K_W-1:0] K_LAST = '1;

  state_t            state;
  state_t            state_n;
  logic [K_W-1:0]    k;
  logic [DATA_W-1:0] buf_a;
  logic [DATA_W-1:0] buf_b;
  logic              hs;

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (start) state_n = FETCH;
      FETCH:   state_n = SEND_A;
      SEND_A:  if (dout_ready) state_n = SEND_B;
      SEND_B:  if (dout_ready) state_n = (k == K_LAST) ? DONE : FETCH;
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    busy       = 1'b0;
    done       = 1'b0;
    AddrA      = '0;
    AddrB      = '0;
    dout       = '0;
    dout_addr  = '0;
    dout_valid = 1'b0;
    case (state)
      FETCH: begin
        busy  = 1'b1;
        AddrA = {k, 1'b0};
        AddrB = {k, 1'b1};
      end
      SEND_A: begin
        busy       = 1'b1;
        dout       = buf_a;
        dout_addr  = {k, 1'b0};
        dout_valid = 1'b1;
      end
      SEND_B: begin
        busy       = 1'b1;
        dout       = buf_b;
        dout_addr  = {k, 1'b1};
        dout_valid = 1'b1;
      end
      DONE:    done = 1'b1;
      default: ;
    endcase
    wr_hold = busy;
  end

  assign hs = dout_valid && dout_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      k        <= '0;
      buf_a    <= '0;
      buf_b    <= '0;
      checksum <= '0;
    end else begin
      state <= state_n;
      case (state)
        IDLE: begin
          if (start) begin
            k        <= '0;
            checksum <= '0;
          end
        end
        FETCH: begin
          buf_a <= BusA;
          buf_b <= BusB;
        end
        SEND_B: begin
          if (dout_ready && (k != K_LAST)) k <= k + 1'b1;
        end
        default: ;
      endcase
      // Clear-on-start and a handshake can never fall in the same cycle.
      if (hs) checksum <= checksum + dout;
    end
  end

endmodule

// File: tb/tb_reg_16bit_file_dump.sv
// Bench for reg_16bit_file_dump: a behavioural register file with gated writes,
// a word scoreboard fed at start time, and per-run timing/checksum checks.
module tb_reg_16bit_file_dump;
  localparam int DW   = 16;
  localparam int AW   = 4;
  localparam int NREG = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          busy;
  logic          wr_hold;
  logic          done;
  logic [AW-1:0] AddrA;
  logic [AW-1:0] AddrB;
  logic [DW-1:0] BusA;
  logic [DW-1:0] BusB;
  logic [DW-1:0] dout;
  logic [AW-1:0] dout_addr;
  logic          dout_valid;
  logic          dout_ready;
  logic [DW-1:0] checksum;

  logic          reg_write;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic [DW-1:0] rf  [NREG];
  logic [DW-1:0] img [NREG];

  logic [AW+DW-1:0] exp_q[$];
  logic [AW+DW-1:0] exp_w;
  logic [AW+DW-1:0] prev_word;
  logic             prev_stall = 1'b0;
  int n_vec = 0;
  int n_err = 0;
  int done_cnt = 0;
  int stall_cnt = 0;

  always #5 clk = ~clk;

  reg_16bit_file_dump #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .wr_hold(wr_hold),
    .done(done), .AddrA(AddrA), .AddrB(AddrB), .BusA(BusA), .BusB(BusB),
    .dout(dout), .dout_addr(dout_addr), .dout_valid(dout_valid),
    .dout_ready(dout_ready), .checksum(checksum)
  );

  // Register file with the pipeline's RegWrite gated by wr_hold.
  assign BusA = rf[AddrA];
  assign BusB = rf[AddrB];
  always @(posedge clk) if (reg_write && !wr_hold) rf[wr_addr] <= wr_data;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  // Monitor: scoreboard pops, stall stability and idle-output rules.
  always @(negedge clk) begin
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      check("wr_hold", {31'd0, wr_hold}, {31'd0, busy});
      if (!busy || dout_valid) check("addr_idle", {24'd0, AddrA, AddrB}, 32'd0);
      if (!dout_valid) check("dout_idle", {12'd0, dout_addr, dout}, 32'd0);
      if (prev_stall) check("stall_hold", {11'd0, dout_valid, dout_addr, dout}, {11'd0, 1'b1, prev_word});
      if (done) done_cnt++;
      if (dout_valid && dout_ready) begin
        if (exp_q.size() == 0) begin
          check("extra_word", 32'(exp_q.size()), 32'd1);
        end else begin
          exp_w = exp_q.pop_front();
          check("word", {12'd0, dout_addr, dout}, {12'd0, exp_w});
        end
      end
      if (dout_valid && !dout_ready) stall_cnt++;
      prev_stall = dout_valid && !dout_ready;
      prev_word  = {dout_addr, dout};
    end
  end

  // Driver tasks are entered and left 1 time unit after a rising edge.
  task automatic write_reg(input int a, input logic [DW-1:0] d);
    reg_write = 1'b1;
    wr_addr   = AW'(a);
    wr_data   = d;
    img[a]    = d;
    @(posedge clk); #1;
    reg_write = 1'b0;
  endtask

  // mode: 0 ready high, 1 ready toggling 1-0-1-0, 2 random ready.
  // start_cyc/hold_cyc/rst_cyc: cycle (after start edge) to pulse start,
  // attempt a write of 0xBEEF to R3, or assert reset; 0 = never.
  task automatic run_dump(input int mode, input int start_cyc, input int hold_cyc, input int rst_cyc);
    logic [DW-1:0] sum;
    int busy_cnt;
    int done_cyc;
    bit stop;
    sum = '0;
    busy_cnt = 0;
    done_cyc = 0;
    stop = 1'b0;
    for (int i = 0; i < NREG; i++) begin
      exp_q.push_back({AW'(i), img[i]});
      sum += img[i];
    end
    done_cnt  = 0;
    stall_cnt = 0;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int c = 1; c <= 300 && !stop; c++) begin
      case (mode)
        0:       dout_ready = 1'b1;
        1:       dout_ready = c[0];
        default: dout_ready = 1'($urandom_range(0, 1));
      endcase
      start     = (c == start_cyc);
      rst       = (c == rst_cyc);
      reg_write = (c == hold_cyc);
      wr_addr   = 4'd3;
      wr_data   = 16'hBEEF;
      @(negedge clk);
      if (busy) busy_cnt++;
      if (done) begin
        done_cyc = c;
        stop = 1'b1;
      end
      if (rst_cyc != 0 && c == rst_cyc + 1) begin
        check("rst_ctrl", {20'd0, busy, wr_hold, done, dout_valid, AddrA, AddrB}, 32'd0);
        check("rst_data", {dout, checksum}, 32'd0);
        check("rst_dout_addr", {28'd0, dout_addr}, 32'd0);
        check("rst_no_done", 32'(done_cnt), 32'd0);
        check("rst_words_left", 32'(exp_q.size()), 32'd9);
        exp_q.delete();
        stop = 1'b1;
      end
      @(posedge clk); #1;
    end
    start = 1'b0;
    rst = 1'b0;
    reg_write = 1'b0;
    if (rst_cyc == 0) begin
      check("done_seen", {31'd0, done_cyc != 0}, 32'd1);
      check("busy_cycles", 32'(busy_cnt), 32'(24 + stall_cnt));
      check("done_cycle", 32'(done_cyc), 32'(25 + stall_cnt));
      check("checksum", {16'd0, checksum}, {16'd0, sum});
      check("words_left", 32'(exp_q.size()), 32'd0);
      check("done_count", 32'(done_cnt), 32'd1);
      exp_q.delete();
      @(negedge clk);
      check("idle_after", {29'd0, busy, done, dout_valid}, 32'd0);
      check("checksum_held", {16'd0, checksum}, {16'd0, sum});
      @(posedge clk); #1;
    end
  endtask

  task automatic preload_count();
    for (int i = 0; i < 15; i++) write_reg(i, DW'(i + 1));
    write_reg(15, 16'h0000);
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    dout_ready = 1'b0;
    reg_write = 1'b0;
    wr_addr = '0;
    wr_data = '0;
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    check("reset_ctrl", {20'd0, busy, wr_hold, done, dout_valid, AddrA, AddrB}, 32'd0);
    check("reset_data", {dout, checksum}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    preload_count();
    run_dump(0, 0, 0, 0);
    check("sum_0078", {16'd0, checksum}, 32'h0000_0078);

    run_dump(1, 0, 0, 0);
    check("bp_sum_0078", {16'd0, checksum}, 32'h0000_0078);

    run_dump(0, 0, 2, 0);
    check("r3_after_hold", {16'd0, rf[3]}, 32'h0000_0004);

    for (int i = 0; i < NREG; i++) write_reg(i, 16'h1000);
    run_dump(0, 0, 0, 0);
    check("wrap_1000", {16'd0, checksum}, 32'h0000_0000);

    for (int i = 0; i < NREG; i++) write_reg(i, 16'hFFFF);
    run_dump(1, 0, 0, 0);
    check("wrap_ffff", {16'd0, checksum}, 32'h0000_FFF0);

    for (int i = 0; i < NREG; i++) write_reg(i, DW'($urandom_range(0, 16'hFFFF)));
    run_dump(2, 0, 0, 0);

    preload_count();
    run_dump(0, 0, 0, 12);
    @(posedge clk); #1;
    run_dump(0, 0, 0, 0);

    run_dump(0, 10, 0, 0);
    run_dump(2, 7, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
